// File: rtl/axi_byte_slave_mem.sv
// Byte-wide AXI-style slave memory with independent read and write channels.
// Define SLV_MEM_INIT_EN to load mem[i] = i while rst is high.
module axi_byte_slave_mem #(
  parameter int DEPTH  = 256,
  parameter int MAXLEN = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ARVALID,
  output logic       ARREADY,
  input  logic [7:0] ARADDR,
  input  logic [3:0] ARLEN,
  input  logic [3:0] ARID,
  output logic       RVALID,
  input  logic       RREADY,
  output logic [7:0] RDATA,
  output logic       RRESP,
  output logic       RLAST,
  input  logic       AWVALID,
  output logic       AWREADY,
  input  logic [7:0] AWADDR,
  input  logic [3:0] AWID,
  input  logic       WVALID,
  output logic       WREADY,
  input  logic [7:0] WDATA,
  input  logic       WLAST,
  output logic       BVALID,
  input  logic       BREADY,
  output logic [4:0] BRESP
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {R_IDLE, R_DATA} r_state_e;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;

  function automatic logic in_range(input logic [7:0] a);
    return ({24'd0, a} < 32'(DEPTH));
  endfunction

  logic [7:0] mem_q [DEPTH];

  r_state_e   r_state_q, r_state_d;
  logic [7:0] r_addr_q, r_addr_d;
  logic [3:0] r_len_q, r_len_d;
  logic [3:0] r_beat_q, r_beat_d;
  logic [3:0] r_id_q, r_id_d;
  logic       arready_q, arready_d;
  logic       rvalid_q, rvalid_d;
  logic [7:0] rdata_q, rdata_d;
  logic       rresp_q, rresp_d;
  logic       rlast_q, rlast_d;

  w_state_e   w_state_q, w_state_d;
  logic [7:0] w_addr_q, w_addr_d;
  logic [3:0] w_id_q, w_id_d;
  logic       w_err_q, w_err_d;
  logic [7:0] w_cnt_q, w_cnt_d;
  logic       awready_q, awready_d;
  logic       wready_q, wready_d;
  logic       bvalid_q, bvalid_d;
  logic [4:0] bresp_q, bresp_d;

  logic       ar_hs;
  logic [7:0] r_rd_addr;
  logic       r_rd_ok;
  logic [7:0] r_rd_byte;
  logic       mem_we;
  logic       w_ok;
  logic [7:0] w_cnt_inc;
  logic       w_err_nxt;

  assign ar_hs     = (r_state_q == R_IDLE) && arready_q && ARVALID;
  assign r_rd_addr = ar_hs ? ARADDR : r_addr_q + 8'd1;
  assign r_rd_ok   = in_range(r_rd_addr);
  assign r_rd_byte = r_rd_ok ? mem_q[r_rd_addr[AW-1:0]] : 8'h00;

  always_comb begin
    r_state_d = r_state_q;
    r_addr_d  = r_addr_q;
    r_len_d   = r_len_q;
    r_beat_d  = r_beat_q;
    r_id_d    = r_id_q;
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    rlast_d   = rlast_q;
    unique case (r_state_q)
      R_IDLE: begin
        arready_d = 1'b1;
        if (ar_hs) begin
          r_state_d = R_DATA;
          r_addr_d  = ARADDR;
          r_len_d   = ARLEN;
          r_id_d    = ARID;
          r_beat_d  = 4'd0;
          arready_d = 1'b0;
          rvalid_d  = 1'b1;
          rdata_d   = r_rd_byte;
          rresp_d   = !r_rd_ok;
          rlast_d   = (ARLEN == 4'd0);
        end
      end
      R_DATA: begin
        if (rvalid_q && RREADY) begin
          if (rlast_q) begin
            r_state_d = R_IDLE;
            arready_d = 1'b1;
            rvalid_d  = 1'b0;
            rdata_d   = 8'h00;
            rresp_d   = 1'b0;
            rlast_d   = 1'b0;
          end else begin
            r_addr_d = r_rd_addr;
            r_beat_d = r_beat_q + 4'd1;
            rdata_d  = r_rd_byte;
            rresp_d  = !r_rd_ok;
            rlast_d  = (r_beat_q + 4'd1 == r_len_q);
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state_q <= R_IDLE;
      r_addr_q  <= 8'h00;
      r_len_q   <= 4'd0;
      r_beat_q  <= 4'd0;
      r_id_q    <= 4'd0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= 8'h00;
      rresp_q   <= 1'b0;
      rlast_q   <= 1'b0;
    end else begin
      r_state_q <= r_state_d;
      r_addr_q  <= r_addr_d;
      r_len_q   <= r_len_d;
      r_beat_q  <= r_beat_d;
      r_id_q    <= r_id_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      rlast_q   <= rlast_d;
    end
  end

  assign w_ok      = in_range(w_addr_q);
  assign w_cnt_inc = (w_cnt_q == 8'hFF) ? 8'hFF : w_cnt_q + 8'd1;

  // Overflow: this beat reaches MAXLEN yet the burst is still open.
  assign w_err_nxt = w_err_q || !w_ok ||
                     (({24'd0, w_cnt_inc} >= 32'(MAXLEN)) && !WLAST);

  always_comb begin
    w_state_d = w_state_q;
    w_addr_d  = w_addr_q;
    w_id_d    = w_id_q;
    w_err_d   = w_err_q;
    w_cnt_d   = w_cnt_q;
    awready_d = awready_q;
    wready_d  = wready_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    mem_we    = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        awready_d = 1'b1;
        if (awready_q && AWVALID) begin
          w_state_d = W_DATA;
          w_addr_d  = AWADDR;
          w_id_d    = AWID;
          w_err_d   = 1'b0;
          w_cnt_d   = 8'd0;
          awready_d = 1'b0;
          wready_d  = 1'b1;
        end
      end
      W_DATA: begin
        if (wready_q && WVALID) begin
          mem_we   = w_ok;
          w_addr_d = w_addr_q + 8'd1;
          w_cnt_d  = w_cnt_inc;
          w_err_d  = w_err_nxt;
          if (WLAST) begin
            w_state_d = W_RESP;
            wready_d  = 1'b0;
            bvalid_d  = 1'b1;
            bresp_d   = {w_id_q, w_err_nxt};
          end
        end
      end
      W_RESP: begin
        if (bvalid_q && BREADY) begin
          w_state_d = W_IDLE;
          bvalid_d  = 1'b0;
          bresp_d   = 5'd0;
          awready_d = 1'b1;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_state_q <= W_IDLE;
      w_addr_q  <= 8'h00;
      w_id_q    <= 4'd0;
      w_err_q   <= 1'b0;
      w_cnt_q   <= 8'd0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= 5'd0;
    end else begin
      w_state_q <= w_state_d;
      w_addr_q  <= w_addr_d;
      w_id_q    <= w_id_d;
      w_err_q   <= w_err_d;
      w_cnt_q   <= w_cnt_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
    end
  end

  // Same-edge write is non-blocking, so a concurrent read load sees old data.
  always_ff @(posedge clk) begin
`ifdef SLV_MEM_INIT_EN
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= i[7:0];
      end
    end else if (mem_we) begin
      mem_q[w_addr_q[AW-1:0]] <= WDATA;
    end
`else
    if (!rst && mem_we) begin
      mem_q[w_addr_q[AW-1:0]] <= WDATA;
    end
`endif
  end

  assign ARREADY = arready_q;
  assign RVALID  = rvalid_q;
  assign RDATA   = rdata_q;
  assign RRESP   = rresp_q;
  assign RLAST   = rlast_q;
  assign AWREADY = awready_q;
  assign WREADY  = wready_q;
  assign BVALID  = bvalid_q;
  assign BRESP   = bresp_q;

endmodule

// File: tb/tb_axi_byte_slave_mem.sv
// Directed bench for axi_byte_slave_mem; a DEPTH=128 copy shares the inputs
// so range errors can be observed alongside the full-depth instance.
module tb_axi_byte_slave_mem;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ARVALID = 1'b0;
  logic [7:0] ARADDR = 8'h00;
  logic [3:0] ARLEN = 4'd0;
  logic [3:0] ARID = 4'd0;
  logic       RREADY = 1'b0;
  logic       AWVALID = 1'b0;
  logic [7:0] AWADDR = 8'h00;
  logic [3:0] AWID = 4'd0;
  logic       WVALID = 1'b0;
  logic [7:0] WDATA = 8'h00;
  logic       WLAST = 1'b0;
  logic       BREADY = 1'b0;

  logic       ARREADY, RVALID, RRESP, RLAST;
  logic       AWREADY, WREADY, BVALID;
  logic [7:0] RDATA;
  logic [4:0] BRESP;

  logic       ARREADY_2, RVALID_2, RRESP_2, RLAST_2;
  logic       AWREADY_2, WREADY_2, BVALID_2;
  logic [7:0] RDATA_2;
  logic [4:0] BRESP_2;

  int n_chk = 0;
  int n_fail = 0;

  logic [7:0] wbuf [32];
  logic [7:0] rd [16];
  logic [7:0] rd2 [16];
  logic       rr [16];
  logic       rr2 [16];
  logic       rl [16];
  logic       rl2 [16];
  logic [4:0] br, br2;

  axi_byte_slave_mem #(.DEPTH(256), .MAXLEN(16)) u_dut (
    .clk(clk), .rst(rst),
    .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR),
    .ARLEN(ARLEN), .ARID(ARID),
    .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA),
    .RRESP(RRESP), .RLAST(RLAST),
    .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR),
    .AWID(AWID),
    .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA),
    .WLAST(WLAST),
    .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP)
  );

  axi_byte_slave_mem #(.DEPTH(128), .MAXLEN(16)) u_dut128 (
    .clk(clk), .rst(rst),
    .ARVALID(ARVALID), .ARREADY(ARREADY_2), .ARADDR(ARADDR),
    .ARLEN(ARLEN), .ARID(ARID),
    .RVALID(RVALID_2), .RREADY(RREADY), .RDATA(RDATA_2),
    .RRESP(RRESP_2), .RLAST(RLAST_2),
    .AWVALID(AWVALID), .AWREADY(AWREADY_2), .AWADDR(AWADDR),
    .AWID(AWID),
    .WVALID(WVALID), .WREADY(WREADY_2), .WDATA(WDATA),
    .WLAST(WLAST),
    .BVALID(BVALID_2), .BREADY(BREADY), .BRESP(BRESP_2)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_arready"}, 32'(ARREADY), 0);
    check({tag, "_awready"}, 32'(AWREADY), 0);
    check({tag, "_rvalid"}, 32'(RVALID), 0);
    check({tag, "_rlast"}, 32'(RLAST), 0);
    check({tag, "_rresp"}, 32'(RRESP), 0);
    check({tag, "_rdata"}, 32'(RDATA), 0);
    check({tag, "_wready"}, 32'(WREADY), 0);
    check({tag, "_bvalid"}, 32'(BVALID), 0);
    check({tag, "_bresp"}, 32'(BRESP), 0);
  endtask

  task automatic write_burst(input logic [7:0] a,
                             input logic [3:0] id,
                             input int n);
    int k = 0;
    AWVALID = 1'b1;
    AWADDR  = a;
    AWID    = id;
    while (!AWREADY && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("awready", 32'(AWREADY), 1);
    @(negedge clk);
    AWVALID = 1'b0;
    check("wready", 32'(WREADY), 1);
    for (int i = 0; i < n; i++) begin
      WVALID = 1'b1;
      WDATA  = wbuf[i];
      WLAST  = (i == n - 1);
      @(negedge clk);
    end
    WVALID = 1'b0;
    WLAST  = 1'b0;
    BREADY = 1'b1;
    check("bvalid", 32'(BVALID), 1);
    br  = BRESP;
    br2 = BRESP_2;
    @(negedge clk);
    BREADY = 1'b0;
    check("bvalid_1cyc", 32'(BVALID), 0);
  endtask

  task automatic read_burst(input logic [7:0] a,
                            input int len,
                            input bit stall);
    int k = 0;
    ARVALID = 1'b1;
    ARADDR  = a;
    ARLEN   = 4'(len);
    ARID    = 4'(len);
    while (!ARREADY && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("arready", 32'(ARREADY), 1);
    @(negedge clk);
    ARVALID = 1'b0;
    check("rvalid_lat", 32'(RVALID), 1);
    check("arready_busy", 32'(ARREADY), 0);
    for (int b = 0; b <= len; b++) begin
      if (stall) begin
        RREADY = 1'b0;
        @(negedge clk);
        check("hold_v", 32'(RVALID), 1);
        check("hold_d", 32'(RDATA), 32'(wbuf[b]));
        check("hold_l", 32'(RLAST), 32'(b == len));
      end
      RREADY = 1'b1;
      check("rvalid", 32'(RVALID), 1);
      rd[b]  = RDATA;
      rr[b]  = RRESP;
      rl[b]  = RLAST;
      rd2[b] = RDATA_2;
      rr2[b] = RRESP_2;
      rl2[b] = RLAST_2;
      @(negedge clk);
    end
    RREADY = 1'b0;
    check("rvalid_end", 32'(RVALID), 0);
    check("arready_end", 32'(ARREADY), 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    check_reset_outs("rst0");
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_arready", 32'(ARREADY), 1);
    check("post_rst_awready", 32'(AWREADY), 1);

    wbuf[0] = 8'hA5;
    write_burst(8'h10, 4'd3, 1);
    check("t1_bresp", 32'(br), 'h06);

    read_burst(8'h10, 0, 1'b0);
    check("t2_rdata", 32'(rd[0]), 'hA5);
    check("t2_rresp", 32'(rr[0]), 0);
    check("t2_rlast", 32'(rl[0]), 1);

    wbuf[0] = 8'h11;
    wbuf[1] = 8'h22;
    wbuf[2] = 8'h33;
    wbuf[3] = 8'h44;
    write_burst(8'hFE, 4'd5, 4);
    check("t3_bresp", 32'(br), 'h0A);
    read_burst(8'hFE, 3, 1'b1);
    check("t3_d0", 32'(rd[0]), 'h11);
    check("t3_d1", 32'(rd[1]), 'h22);
    check("t3_d2", 32'(rd[2]), 'h33);
    check("t3_d3", 32'(rd[3]), 'h44);
    check("t3_l0", 32'(rl[0]), 0);
    check("t3_l2", 32'(rl[2]), 0);
    check("t3_l3", 32'(rl[3]), 1);
    check("t3_r3", 32'(rr[3]), 0);

    wbuf[0] = 8'h5A;
    write_burst(8'h7F, 4'd1, 1);
    check("t4_bresp_7f", 32'(br2), 'h02);
    read_burst(8'h7F, 1, 1'b0);
    check("t4_d0", 32'(rd2[0]), 'h5A);
    check("t4_r0", 32'(rr2[0]), 0);
    check("t4_l0", 32'(rl2[0]), 0);
    check("t4_d1", 32'(rd2[1]), 0);
    check("t4_r1", 32'(rr2[1]), 1);
    check("t4_l1", 32'(rl2[1]), 1);
    wbuf[0] = 8'h77;
    write_burst(8'h80, 4'd2, 1);
    check("t4_bresp_80_d128", 32'(br2), 'h05);
    check("t4_bresp_80_d256", 32'(br), 'h04);

    for (int i = 0; i < 17; i++) wbuf[i] = 8'(i);
    write_burst(8'h20, 4'd7, 17);
    check("t5_bresp_17", 32'(br), 'h0F);
    write_burst(8'h40, 4'd8, 16);
    check("t5_bresp_16", 32'(br), 'h10);
    read_burst(8'h20, 15, 1'b0);
    check("t5_d0", 32'(rd[0]), 0);
    check("t5_d9", 32'(rd[9]), 9);
    check("t5_d15", 32'(rd[15]), 15);
    check("t5_l14", 32'(rl[14]), 0);
    check("t5_l15", 32'(rl[15]), 1);

    AWVALID = 1'b1;
    AWADDR  = 8'h60;
    AWID    = 4'd9;
    @(negedge clk);
    AWVALID = 1'b0;
    WVALID  = 1'b1;
    WDATA   = 8'hEE;
    WLAST   = 1'b0;
    @(negedge clk);
    WVALID  = 1'b0;
    ARVALID = 1'b1;
    ARADDR  = 8'h20;
    ARLEN   = 4'd7;
    @(negedge clk);
    ARVALID = 1'b0;
    RREADY  = 1'b1;
    repeat (2) @(negedge clk);
    check("t6_beat2", 32'(RDATA), 2);
    check("t6_wready", 32'(WREADY), 1);
    RREADY = 1'b0;
    rst    = 1'b1;
    @(negedge clk);
    check_reset_outs("t6_rst");
    rst = 1'b0;
    @(negedge clk);
    check("t6_arready", 32'(ARREADY), 1);
    check("t6_awready", 32'(AWREADY), 1);

`ifdef SLV_MEM_INIT_EN
    read_burst(8'h43, 0, 1'b0);
    check("t6_init_43", 32'(rd[0]), 'h43);
`endif
    wbuf[0] = 8'h99;
    write_burst(8'h42, 4'd4, 1);
    check("t6_bresp", 32'(br), 'h08);
    read_burst(8'h42, 0, 1'b0);
    check("t6_rd42", 32'(rd[0]), 'h99);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
